wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
Writeback-stage arbiter that drives the single write port of `registers` (reg_write, write_reg, write_data).
- It merges two result sources into that port: ALU results, which are never stalled, and load results, which are buffered in a small FIFO with a valid/ready handshake.
- It enforces x0 immutability and write-after-write ordering.
- It exports a pending-load scoreboard mask to the hazard logic.

Parameters:
DEPTH, 2, load FIFO entries (power of 2, >=2)
XLEN, 32, data width

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous active-high reset
alu_valid  input  1  ALU result present this cycle (always accepted)
alu_rd  input  5  ALU destination register
alu_data  input  XLEN  ALU result
ld_valid  input  1  load result offered
ld_rd  input  5  load destination register
ld_data  input  XLEN  load result
ld_ready  output  1  load FIFO can accept this cycle
reg_write  output  1  write enable to register file (registered)
write_reg  output  5  write address (registered)
write_data  output  XLEN  write data (registered)
pend_mask  output  32  bit i set when a live load to register i is queued

Behaviour:
- Reset (async, active-high): reg_write=0, write_reg=0, write_data=0, FIFO empty, all entry-live bits 0, pend_mask=0, ld_ready=1.
- ld_ready = !full. It depends only on registered state, so it does not combinationally depend on ld_valid or alu_valid.
- A load is accepted on a posedge when ld_valid && ld_ready.
  - ld_rd==0: accepted, then discarded (not enqueued).
  - Otherwise: enqueued at the tail with live=1.
- ALU request is alu_valid && alu_rd!=0. alu_rd==0 counts as no request.
- Write selection each posedge (outputs registered, 1-cycle latency):
  - If an ALU request is present: reg_write<=1, write_reg<=alu_rd, write_data<=alu_data. The FIFO does not pop.
  - Else if FIFO non-empty: pop head. If head is live: reg_write<=1, write_reg/write_data<=head. If head is killed: reg_write<=0 (the slot is consumed silently).
  - Else reg_write<=0; write_reg/write_data hold their last values.
- Latency:
  - ALU result presented at edge N is visible on the outputs after N and written into the register file at N+1.
  - A load into an empty FIFO with no ALU traffic: enqueued at N, drives outputs after N+1.
- WAW kill: on any edge with an ALU request, every queued entry with rd==alu_rd has its live bit cleared. This prevents an older load from overwriting a younger ALU result.
- Simultaneous ALU request and load acceptance with ld_rd==alu_rd: the ALU is younger, so the load is enqueued already killed (live=0).
- Push and pop in the same edge are allowed when not full. The count is unchanged and pointers wrap modulo DEPTH.
- Full: ld_ready=0 and ld_valid is ignored. A pop on that edge frees a slot for the next cycle only.
- ALU starvation of the FIFO is permitted. There is no fairness counter; the FIFO drains on cycles without an ALU request.
- pend_mask: combinational OR of a one-hot of rd over all queued entries that are live. Killed entries do not contribute.
- Reset asserted mid-operation discards all queued loads immediately. No write is issued for them.
- reg_write is never asserted with write_reg==0.

Test Plan:
- ALU only: reset, then alu_valid=1, rd=7, data=2022 for one cycle. Required: one cycle later reg_write=1, write_reg=7, write_data=2022; the next cycle reg_write=0, and the register file reads 2022 from reg 7.
- Load path: ld_valid=1, rd=17, data=2023 with no ALU traffic. Required: ld_ready=1; pend_mask bit17=1 for one cycle; outputs show 17/2023 two edges after the offer; pend_mask returns to 0.
- Backpressure and priority: hold alu_valid=1 (rd=3) while offering loads rd=10, 11, 12. Required: ld_ready drops to 0 after 2 accepts and the third is held off; after ALU traffic stops, writes 10 then 11 occur in order, then 12 is accepted.
- WAW kill: queue load rd=5, data=0xAAAA, then issue ALU rd=5, data=0xBBBB while it is queued. Required: pend_mask bit5 clears the cycle after the ALU edge; register 5 ends at 0xBBBB; one silent pop cycle occurs with reg_write=0.
- x0 protection: ALU rd=0, data=99, and load rd=0. Required: reg_write stays 0 throughout, and the load is accepted without changing pend_mask.
- Async reset mid-flight: fill the FIFO with 2 loads, then assert reset between edges. Required: reg_write=0, pend_mask=0 and ld_ready=1 immediately; no queued load is ever written after release.

Source files
------------

// File: rtl/wb_arbiter.sv
//------------------------------------------------------------------------------
// wb_arbiter: merges unstallable ALU results and FIFO-buffered load results
// onto the register-file write port, with x0 protection and WAW kill.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
  output logic            reg_write,
  output logic [4:0]      write_reg,
  output logic [XLEN-1:0] write_data,
  output logic [31:0]     pend_mask
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(DEPTH);

  logic [4:0]      r_rd   [DEPTH];
  logic [XLEN-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_live;
  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [c_AW:0]   r_count;

  logic w_full;
  logic w_alu_req;
  logic w_push;
  logic w_push_live;
  logic w_pop;
  logic w_head_live;
  logic [31:0] w_mask;

  assign w_full      = (r_count == c_FULL);
  assign ld_ready    = ~w_full;
  assign w_alu_req   = alu_valid && (alu_rd != 5'd0);
  // Loads to x0 are still handshaken so the producer never stalls on them.
  assign w_push      = ld_valid && ~w_full && (ld_rd != 5'd0);
  // A same-cycle ALU write to the same rd is younger, so the load arrives dead.
  assign w_push_live = ~(w_alu_req && (ld_rd == alu_rd));
  assign w_pop       = ~w_alu_req && (r_count != '0);
  assign w_head_live = r_live[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wptr]   <= ld_rd;
      r_data[r_wptr] <= ld_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_live     <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      reg_write  <= 1'b0;
      write_reg  <= 5'd0;
      write_data <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_alu_req && (r_rd[i] == alu_rd)) begin
          r_live[i] <= 1'b0;
        end
      end
      // Popped slots drop their live bit so pend_mask covers only occupied entries.
      if (w_pop) begin
        r_live[r_rptr] <= 1'b0;
        r_rptr         <= r_rptr + 1'b1;
      end
      if (w_push) begin
        r_live[r_wptr] <= w_push_live;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end

      if (w_alu_req) begin
        reg_write  <= 1'b1;
        write_reg  <= alu_rd;
        write_data <= alu_data;
      end else if (w_pop && w_head_live) begin
        reg_write  <= 1'b1;
        write_reg  <= r_rd[r_rptr];
        write_data <= r_data[r_rptr];
      end else begin
        reg_write  <= 1'b0;
      end
    end
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i]) begin
        w_mask[r_rd[i]] = 1'b1;
      end
    end
  end

  assign pend_mask = w_mask;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
//------------------------------------------------------------------------------
// tb_wb_arbiter: scoreboard bench for wb_arbiter write ordering and kill rules.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_arbiter;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = 5'd0;
  logic [31:0] alu_data = 32'd0;
  logic        ld_valid = 1'b0;
  logic [4:0]  ld_rd = 5'd0;
  logic [31:0] ld_data = 32'd0;
  logic        ld_ready;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] pend_mask;

  int   n_tests = 0;
  int   n_fail  = 0;
  wr_t  q_exp[$];
  logic [31:0] rf [32];

  wb_arbiter #(.DEPTH(2), .XLEN(32)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .ld_valid   (ld_valid),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .pend_mask  (pend_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
  end

  // Register-file model: a write presented after edge N lands at edge N+1.
  always @(posedge clk) begin
    if (reg_write) rf[write_reg] <= write_data;
  end

  always @(negedge clk) begin
    if (reg_write) begin
      if (q_exp.size() == 0) begin
        check("spurious_write", {59'd0, reg_write}, 64'd0);
      end else begin
        wr_t e;
        e = q_exp.pop_front();
        check("wr_rd", {59'd0, write_reg}, {59'd0, e.rd});
        check("wr_data", {32'd0, write_data}, {32'd0, e.data});
      end
    end
  end

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    wr_t e;
    e.rd   = rd;
    e.data = data;
    q_exp.push_back(e);
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_reg_write", {63'd0, reg_write}, 64'd0);
    check("rst_write_reg", {59'd0, write_reg}, 64'd0);
    check("rst_write_data", {32'd0, write_data}, 64'd0);
    check("rst_pend_mask", {32'd0, pend_mask}, 64'd0);
    check("rst_ld_ready", {63'd0, ld_ready}, 64'd1);
    reset = 1'b0;
    @(negedge clk);

    // ALU only
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'd2022;
    expect_wr(5'd7, 32'd2022);
    @(negedge clk);
    check("alu_reg_write", {63'd0, reg_write}, 64'd1);
    idle();
    @(negedge clk);
    check("alu_wr_drop", {63'd0, reg_write}, 64'd0);
    check("alu_rf7", {32'd0, rf[7]}, 64'd2022);

    // Load path
    check("ld_ready_idle", {63'd0, ld_ready}, 64'd1);
    ld_valid = 1'b1; ld_rd = 5'd17; ld_data = 32'd2023;
    expect_wr(5'd17, 32'd2023);
    @(negedge clk);
    idle();
    check("ld_pend17", {32'd0, pend_mask}, {32'd0, 32'h1 << 17});
    @(negedge clk);
    check("ld_pend_clr", {32'd0, pend_mask}, 64'd0);
    check("ld_reg_write", {63'd0, reg_write}, 64'd1);
    @(negedge clk);
    check("ld_rf17", {32'd0, rf[17]}, 64'd2023);

    // Backpressure and ALU priority
    for (int c = 0; c < 6; c++) begin
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'd300 + c;
      expect_wr(5'd3, 32'd300 + c);
      ld_valid = 1'b1;
      ld_rd    = (c == 0) ? 5'd10 : (c == 1) ? 5'd11 : 5'd12;
      ld_data  = 32'h1000 + {27'd0, ld_rd};
      check("bp_ld_ready", {63'd0, ld_ready}, {63'd0, c < 2});
      if (c == 3) check("bp_pend", {32'd0, pend_mask}, {32'd0, 32'h0000_0C00});
      @(negedge clk);
    end
    alu_valid = 1'b0;
    check("bp_full_hold", {63'd0, ld_ready}, 64'd0);
    expect_wr(5'd10, 32'h100A);
    expect_wr(5'd11, 32'h100B);
    @(negedge clk);
    check("bp_ready_again", {63'd0, ld_ready}, 64'd1);
    expect_wr(5'd12, 32'h100C);
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    check("bp_drained", {32'd0, pend_mask}, 64'd0);

    // WAW kill of a queued load
    ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'hAAAA;
    @(negedge clk);
    ld_valid = 1'b0;
    check("waw_pend5", {32'd0, pend_mask}, {32'd0, 32'h20});
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hBBBB;
    expect_wr(5'd5, 32'hBBBB);
    @(negedge clk);
    alu_valid = 1'b0;
    check("waw_pend_clr", {32'd0, pend_mask}, 64'd0);
    @(negedge clk);
    check("waw_silent_pop", {63'd0, reg_write}, 64'd0);
    check("waw_empty", {63'd0, ld_ready}, 64'd1);
    check("waw_rf5", {32'd0, rf[5]}, 64'hBBBB);
    repeat (2) @(negedge clk);

    // Same-edge ALU and load to the same rd: load enqueued dead
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9A;
    ld_valid  = 1'b1; ld_rd  = 5'd9; ld_data  = 32'h9B;
    expect_wr(5'd9, 32'h9A);
    @(negedge clk);
    idle();
    check("same_pend", {32'd0, pend_mask}, 64'd0);
    @(negedge clk);
    check("same_silent", {63'd0, reg_write}, 64'd0);
    repeat (2) @(negedge clk);
    check("same_rf9", {32'd0, rf[9]}, 64'h9A);

    // x0 protection
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'd99;
    ld_valid  = 1'b1; ld_rd  = 5'd0; ld_data  = 32'd98;
    check("x0_ready", {63'd0, ld_ready}, 64'd1);
    @(negedge clk);
    idle();
    check("x0_pend", {32'd0, pend_mask}, 64'd0);
    check("x0_no_write", {63'd0, reg_write}, 64'd0);
    @(negedge clk);
    check("x0_no_write2", {63'd0, reg_write}, 64'd0);
    check("x0_rf0", {32'd0, rf[0]}, 64'd0);

    // Async reset with a full FIFO
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
    ld_valid  = 1'b1; ld_rd  = 5'd20; ld_data = 32'h20;
    expect_wr(5'd4, 32'h44);
    @(negedge clk);
    alu_data = 32'h45; ld_rd = 5'd21; ld_data = 32'h21;
    expect_wr(5'd4, 32'h45);
    @(negedge clk);
    idle();
    check("ar_pend_full", {32'd0, pend_mask}, {32'd0, 32'h0030_0000});
    check("ar_full", {63'd0, ld_ready}, 64'd0);
    #2 reset = 1'b1;
    #1;
    check("ar_reg_write", {63'd0, reg_write}, 64'd0);
    check("ar_pend", {32'd0, pend_mask}, 64'd0);
    check("ar_ready", {63'd0, ld_ready}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("ar_rf20", {32'd0, rf[20]}, 64'd0);
    check("ar_rf21", {32'd0, rf[21]}, 64'd0);

    check("sb_empty", 64'(q_exp.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
